// File: rtl/bbc_keyboard_matrix.sv
// BBC micro keyboard: 10x8 key matrix fed by host make/break events, answering
// System VIA probes on PA7 and raising CA2 from a free-running column scan.
module bbc_keyboard_matrix #(
  parameter logic [7:0] DIP_LINKS = 8'h00
) (
  input  logic       clk,
  input  logic       nRESET,
  input  logic       en_1mhz,
  input  logic       nKB_EN,
  input  logic [6:0] pa_in,
  output logic       pa7_out,
  output logic       pa7_oe,
  output logic       ca2,
  input  logic       key_valid,
  input  logic       key_make,
  input  logic [6:0] key_code,
  input  logic       clear_all,
  output logic [3:0] col_cnt
);

  localparam logic [3:0] NUM_COLS = 4'd10;

  // Key events are valid-only strobes: there is no ready, every pulse of
  // key_valid is consumed on the clk edge where it is seen high.
  logic [7:0][9:0] matrix_q, matrix_d;
  logic [3:0]      col_cnt_q, col_cnt_d;
  logic            ca2_q, ca2_d;

  logic [2:0] ev_row;
  logic [3:0] ev_col;
  logic [2:0] rd_row;
  logic [3:0] rd_col;
  logic [9:0] rd_bits;
  logic [3:0] sel;
  logic [3:0] sel_safe;
  logic [7:0] sel_col_bits;

  assign ev_row = key_code[6:4];
  assign ev_col = key_code[3:0];
  assign rd_row = pa_in[6:4];
  assign rd_col = pa_in[3:0];

  always_comb begin
    matrix_d = matrix_q;
    if (clear_all) begin
      matrix_d = '0;
    end else if (key_valid && (ev_col < NUM_COLS)) begin
      matrix_d[ev_row][ev_col] = key_make;
    end
  end

  always_comb begin
    col_cnt_d = col_cnt_q;
    if (!nKB_EN) begin
      col_cnt_d = pa_in[3:0];
    end else if (en_1mhz) begin
      col_cnt_d = col_cnt_q + 4'd1;
    end
  end

  // Row 0 columns 2..9 are the startup links, not the matrix.
  always_comb begin
    rd_bits = matrix_q[rd_row];
    if (rd_row == 3'd0) begin
      rd_bits = {DIP_LINKS, matrix_q[0][1:0]};
    end
  end

  always_comb begin
    pa7_out = 1'b0;
    pa7_oe  = 1'b0;
    if (!nKB_EN) begin
      pa7_oe = 1'b1;
      if (rd_col < NUM_COLS) begin
        pa7_out = rd_bits[rd_col];
      end
    end
  end

  assign sel      = nKB_EN ? col_cnt_q : pa_in[3:0];
  assign sel_safe = (sel < NUM_COLS) ? sel : 4'd0;

  always_comb begin
    for (int r = 0; r < 8; r++) begin
      sel_col_bits[r] = matrix_q[r][sel_safe];
    end
  end

  // Row 0 (SHIFT, CTRL, links) is excluded from the interrupt.
  always_comb begin
    ca2_d = 1'b0;
    if (sel < NUM_COLS) begin
      ca2_d = |sel_col_bits[7:1];
    end
  end

  always_ff @(posedge clk) begin
    if (!nRESET) begin
      matrix_q  <= '0;
      col_cnt_q <= 4'd0;
      ca2_q     <= 1'b0;
    end else begin
      matrix_q  <= matrix_d;
      col_cnt_q <= col_cnt_d;
      ca2_q     <= ca2_d;
    end
  end

  assign ca2     = ca2_q;
  assign col_cnt = col_cnt_q;

endmodule

// File: tb/tb_bbc_keyboard_matrix.sv
// Bench for bbc_keyboard_matrix: reference key-matrix model, CA2 scoreboard
// with one-clk latency, and direct combinational checks of the PA7 read path.
module tb_bbc_keyboard_matrix;

  localparam logic [7:0] DIP = 8'hA5;

  logic       clk;
  logic       nRESET;
  logic       en_1mhz;
  logic       nKB_EN;
  logic [6:0] pa_in;
  logic       pa7_out;
  logic       pa7_oe;
  logic       ca2;
  logic       key_valid;
  logic       key_make;
  logic [6:0] key_code;
  logic       clear_all;
  logic [3:0] col_cnt;

  int n_tests;
  int n_fail;

  logic [9:0] mdl [8];
  logic [3:0] m_col;
  logic [0:0] exp_q [$];

  bbc_keyboard_matrix #(.DIP_LINKS(DIP)) dut (
    .clk       (clk),
    .nRESET    (nRESET),
    .en_1mhz   (en_1mhz),
    .nKB_EN    (nKB_EN),
    .pa_in     (pa_in),
    .pa7_out   (pa7_out),
    .pa7_oe    (pa7_oe),
    .ca2       (ca2),
    .key_valid (key_valid),
    .key_make  (key_make),
    .key_code  (key_code),
    .clear_all (clear_all),
    .col_cnt   (col_cnt)
  );

  // Clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic model_eff(input logic [6:0] pa);
    logic [2:0] row;
    logic [3:0] col;
    logic [3:0] li;
    row = pa[6:4];
    col = pa[3:0];
    li  = col - 4'd2;
    if (col >= 4'd10) return 1'b0;
    if (row == 3'd0 && col >= 4'd2) return DIP[li[2:0]];
    return mdl[row][col];
  endfunction

  function automatic logic model_ca2(input logic [3:0] s);
    logic v;
    v = 1'b0;
    if (s < 4'd10) begin
      for (int r = 1; r < 8; r++) v = v | mdl[r][s];
    end
    return v;
  endfunction

  // One clock: predict CA2 for the coming edge, advance the model, then
  // compare DUT state at the following falling edge.
  task automatic step();
    logic [3:0] s;
    logic [0:0] e;
    s = nKB_EN ? m_col : pa_in[3:0];
    if (!nRESET) begin
      exp_q.push_back(1'b0);
      for (int r = 0; r < 8; r++) mdl[r] = '0;
      m_col = 4'd0;
    end else begin
      exp_q.push_back(model_ca2(s));
      if (clear_all) begin
        for (int r = 0; r < 8; r++) mdl[r] = '0;
      end else if (key_valid && key_code[3:0] < 4'd10) begin
        mdl[key_code[6:4]][key_code[3:0]] = key_make;
      end
      m_col = nKB_EN ? m_col + {3'd0, en_1mhz} : pa_in[3:0];
    end
    @(negedge clk);
    if (exp_q.size() == 0) begin
      chk("ca2_queue_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("ca2", {31'd0, ca2}, {31'd0, e});
    end
    chk("col_cnt", {28'd0, col_cnt}, {28'd0, m_col});
  endtask

  task automatic key_ev(input logic [2:0] row, input logic [3:0] col, input logic make);
    key_valid = 1'b1;
    key_code  = {row, col};
    key_make  = make;
    step();
    key_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear_all = 1'b1;
    step();
    clear_all = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [6:0] pa);
    pa_in = pa;
    #1;
    chk(tag, {31'd0, pa7_out}, {31'd0, model_eff(pa)});
    chk("pa7_oe_manual", {31'd0, pa7_oe}, 32'd1);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    m_col     = 4'd0;
    for (int r = 0; r < 8; r++) mdl[r] = '0;
    nRESET    = 1'b0;
    en_1mhz   = 1'b0;
    nKB_EN    = 1'b0;
    pa_in     = 7'h00;
    key_valid = 1'b0;
    key_make  = 1'b0;
    key_code  = 7'h00;
    clear_all = 1'b0;

    // Reset state and DIP link reads
    step();
    key_ev(3'd1, 4'd1, 1'b1);
    nRESET = 1'b1;
    #1;
    chk("reset_col_cnt", {28'd0, col_cnt}, 32'd0);
    chk("reset_ca2", {31'd0, ca2}, 32'd0);
    pa_in = 7'h02;
    #1;
    chk("dip_col2", {31'd0, pa7_out}, 32'd1);
    chk("dip_oe", {31'd0, pa7_oe}, 32'd1);
    pa_in = 7'h03;
    #1;
    chk("dip_col3", {31'd0, pa7_out}, 32'd0);
    read_chk("ev_during_reset", 7'h11);
    step();

    // Make/break at (4,7) in manual mode
    pa_in = 7'h47;
    key_ev(3'd4, 4'd7, 1'b1);
    #1;
    chk("make_4_7", {31'd0, pa7_out}, 32'd1);
    step();
    key_ev(3'd4, 4'd7, 1'b0);
    #1;
    chk("break_4_7", {31'd0, pa7_out}, 32'd0);
    step();

    // Auto scan with only (3,5) pressed, strobe every 4 clks from column 0
    do_clear();
    pa_in = 7'h00;
    key_ev(3'd3, 4'd5, 1'b1);
    nKB_EN = 1'b1;
    for (int i = 0; i < 80; i++) begin
      en_1mhz = (i % 4 == 3);
      #1;
      chk("auto_oe", {31'd0, pa7_oe}, 32'd0);
      chk("auto_pa7", {31'd0, pa7_out}, 32'd0);
      step();
    end
    en_1mhz = 1'b0;

    // SHIFT only: never raises CA2
    nKB_EN = 1'b0;
    pa_in  = 7'h00;
    do_clear();
    key_ev(3'd0, 4'd0, 1'b1);
    nKB_EN = 1'b1;
    en_1mhz = 1'b1;
    for (int i = 0; i < 20; i++) step();
    en_1mhz = 1'b0;
    nKB_EN = 1'b0;
    read_chk("shift_read", 7'h00);
    step();

    // Column >= 10 event ignored; full matrix sweep
    do_clear();
    key_ev(3'd2, 4'd12, 1'b1);
    for (int p = 0; p < 128; p++) begin
      read_chk("sweep_after_col12", p[6:0]);
      step();
    end

    // clear_all beats a simultaneous make
    key_ev(3'd2, 4'd3, 1'b1);
    clear_all = 1'b1;
    key_ev(3'd4, 4'd7, 1'b1);
    clear_all = 1'b0;
    read_chk("clear_prio_2_3", 7'h23);
    read_chk("clear_prio_4_7", 7'h47);
    step();

    // Random events racing the scan
    nKB_EN = 1'b1;
    for (int i = 0; i < 200; i++) begin
      en_1mhz   = 1'($urandom_range(0, 1));
      key_valid = ($urandom_range(0, 2) == 0);
      key_code  = 7'($urandom_range(0, 127));
      key_make  = ($urandom_range(0, 3) != 0);
      clear_all = ($urandom_range(0, 40) == 0);
      pa_in     = 7'($urandom_range(0, 127));
      step();
    end
    key_valid = 1'b0;
    clear_all = 1'b0;
    en_1mhz   = 1'b0;

    // Mid-scan reset
    key_ev(3'd5, 4'd2, 1'b1);
    key_ev(3'd1, 4'd9, 1'b1);
    en_1mhz = 1'b1;
    for (int i = 0; i < 6; i++) step();
    nRESET = 1'b0;
    step();
    nRESET = 1'b1;
    step();
    en_1mhz = 1'b0;
    nKB_EN  = 1'b0;
    for (int c = 2; c < 10; c++) read_chk("dip_after_reset", {3'd0, 4'(c)});
    read_chk("key_5_2_after_reset", 7'h52);
    read_chk("key_1_9_after_reset", 7'h19);
    step();
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bbc_keyboard_matrix.md
Name: bbc_keyboard_matrix

Overview:
- Models the BBC micro keyboard, the peripheral at the far end of the System VIA port A / PB3 / CA2 interface.
- Keeps a 10-column x 8-row key matrix, updated from host key make/break events.
- Answers CPU probes: the CPU drives PA[6:0] with PB3 low and reads back the key state on PA7.
- Free-runs a column scan while PB3 is high and raises CA2 when any non-row-0 key is down in the scanned column.

Parameters:
- DIP_LINKS, 8'h00, startup links for row 0, columns 2..9 (bit n-2 = column n); a 1 reads as pressed.

Ports:
- clk  input  1  system clock.
- nRESET  input  1  reset, synchronous, active-low.
- en_1mhz  input  1  one-clk-wide scan-advance strobe.
- nKB_EN  input  1  PB3 from the VIA; 0 = manual (CPU-addressed), 1 = auto-scan.
- pa_in  input  7  VIA PA[6:0]; [3:0] = column, [6:4] = row.
- pa7_out  output  1  addressed key state to VIA PA7.
- pa7_oe  output  1  high while pa7_out is driven.
- ca2  output  1  keypress interrupt to VIA CA2.
- key_valid  input  1  key event strobe, one clk.
- key_make  input  1  1 = press, 0 = release (sampled with key_valid).
- key_code  input  7  {row[2:0], col[3:0]} of the event.
- clear_all  input  1  release every key (host error recovery).
- col_cnt  output  4  current scan column (debug/verification).

Behaviour:
- Reset (nRESET low at clk edge): all 80 matrix bits = 0; col_cnt = 0; ca2 = 0.
- Reset mid-operation discards pending state. Key events arriving during reset are ignored.
- Matrix storage is 80 bits, indexed by row 0..7 and column 0..9.
- Key event (key_valid high): matrix[row][col] <= key_make at the clk edge; visible the next cycle.
- key_code with col >= 10 is ignored with no side effect.
- clear_all: matrix <= 0 and has priority over key_valid in the same cycle.
- Effective key state: rows 1..7 come from the matrix. Row 0, columns 0..1 (SHIFT, CTRL) also come from the matrix. Row 0, columns 2..9 are DIP_LINKS and are not writable by events. Any column >= 10 reads 0.
- Column counter, manual mode (nKB_EN = 0): col_cnt <= pa_in[3:0] every clk (parallel load); en_1mhz is ignored.
- Column counter, auto mode (nKB_EN = 1): col_cnt increments by 1 on each clk where en_1mhz = 1, 4-bit natural wrap 15 -> 0.
- Auto mode scans columns 10..15 as empty.
- Switching manual -> auto: counting resumes from the last loaded value.
- pa7_out (combinational), nKB_EN = 0: pa7_out = effective key at (pa_in[6:4], pa_in[3:0]); pa7_oe = 1. No clk latency, so a CPU read in the same bus cycle is valid.
- pa7_out, nKB_EN = 1: pa7_out = 0; pa7_oe = 0.
- ca2 (registered): ca2 <= OR of the matrix over rows 1..7 at column sel.
  - sel = pa_in[3:0] when nKB_EN = 0, else col_cnt.
  - Row 0 (SHIFT, CTRL, links) never contributes.
  - A column select >= 10 gives ca2 <= 0.
- ca2 latency: 1 clk after the select or matrix change is visible.
- Simultaneous event and scan: the matrix update and the counter advance occur on the same edge. ca2 reflects both one clk later, with no ordering hazard.
- ca2 is level, not pulse. The VIA performs edge detection.

Test Plan:
- Reset with DIP_LINKS = 8'hA5; then manual mode, pa_in = {3'd0, 4'd2} -> pa7_out = 1 (bit 0); pa_in = {3'd0, 4'd3} -> pa7_out = 0; pa7_oe = 1; ca2 = 0; col_cnt = 0.
- key_valid, key_make = 1, key_code = {3'd4, 4'd7}; manual pa_in = 7'h47 -> pa7_out = 1 next cycle; ca2 = 1 one clk later. Break event -> pa7_out = 0, then ca2 = 0 next clk.
- Auto mode with only key (3, 5) pressed, en_1mhz every 4 clks from col_cnt = 0 -> ca2 high exactly while col_cnt = 5 (delayed 1 clk), low otherwise. Wrap 15 -> 0 observed; pa7_oe = 0 throughout.
- Press row 0 col 0 (SHIFT) only, auto scan a full 16 columns -> ca2 never asserts; manual pa_in = 7'h00 -> pa7_out = 1.
- key_code col = 12, make -> no matrix change (all manual reads 0). clear_all and a make event in the same cycle -> matrix all 0.
- Keys pressed, nRESET low for 1 clk during auto scan -> matrix cleared, col_cnt = 0, ca2 = 0 next cycle; DIP links still read back.
